// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the mult/div sequencer: state encoding,
// status-register writeback constants and the default timeout.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdState_t;

  localparam logic [4:0]  RSTATUS_REG   = 5'd30;
  localparam logic [31:0] MULT_EXC_CODE = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE  = 32'd5;

  localparam int DEFAULT_TIMEOUT = 40;

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Bundle of the issue, unit and writeback signals around the sequencer.
// master = the sequencer, slave = the pipeline/unit side that feeds it.
interface multdiv_ctrl_if;

  logic        issue_mult;
  logic        issue_div;
  logic [31:0] issue_A;
  logic [31:0] issue_B;
  logic [4:0]  issue_rd;

  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;

  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  modport master (
    input  issue_mult, issue_div, issue_A, issue_B, issue_rd,
    input  md_result, md_exception, md_resultRDY,
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output stall, busy, wb_valid, wb_rd, wb_data
  );

  modport slave (
    output issue_mult, issue_div, issue_A, issue_B, issue_rd,
    output md_result, md_exception, md_resultRDY,
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  stall, busy, wb_valid, wb_rd, wb_data
  );

endinterface

// File: rtl/md_cycle_counter.sv
// Busy-cycle counter with synchronous clear/enable and a terminal-count
// flag. TIMEOUT < 2^CNT_W, so the count never wraps before tc is seen.
module md_cycle_counter #(
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  // Count enabled cycles; clear wins over enable.
  always_ff @(posedge clock) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CNT_W'(1);
  end

  assign tc = (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the multi-cycle mult/div unit: latches an issued op,
// pulses start, stalls the pipe until the unit answers or times out,
// then emits one writeback beat (redirected to rstatus on exception).
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 6
) (
  input  logic           clock,
  input  logic           reset,
  multdiv_ctrl_if.master mif
);

  mdState_t         state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             issueGo, accept, timeoutHit;

  logic [31:0] opA, opB, resReg;
  logic [4:0]  rdReg;
  logic        isDiv, excReg;

  md_cycle_counter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) uCnt (
    .clock (clock),
    .reset (reset),
    .clr   (issueGo),
    .en    (state == BUSY),
    .cnt   (cnt),
    .tc    (tc)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next state; RDY on the start cycle (cnt==0) is deliberately ignored,
  // and a late RDY on the terminal cycle still beats the timeout.
  always_comb begin
    nxt        = state;
    issueGo    = 1'b0;
    accept     = 1'b0;
    timeoutHit = 1'b0;
    unique case (state)
      IDLE: if (mif.issue_mult || mif.issue_div) begin
        issueGo = 1'b1;
        nxt     = BUSY;
      end
      BUSY: if (mif.md_resultRDY && (cnt != '0)) begin
        accept = 1'b1;
        nxt    = DONE;
      end else if (tc) begin
        timeoutHit = 1'b1;
        nxt        = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Operand/op latches on issue; result capture on accept or timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      opA    <= '0;
      opB    <= '0;
      rdReg  <= '0;
      isDiv  <= 1'b0;
      resReg <= '0;
      excReg <= 1'b0;
    end else begin
      if (issueGo) begin
        opA   <= mif.issue_A;
        opB   <= mif.issue_B;
        rdReg <= mif.issue_rd;
        isDiv <= !mif.issue_mult;  // mult wins when both are raised
      end
      if (accept) begin
        resReg <= mif.md_result;
        excReg <= mif.md_exception;
      end else if (timeoutHit) begin
        excReg <= 1'b1;
      end
    end
  end

  assign mif.md_operandA  = opA;
  assign mif.md_operandB  = opB;
  assign mif.md_ctrl_MULT = (state == BUSY) && (cnt == '0) && !isDiv;
  assign mif.md_ctrl_DIV  = (state == BUSY) && (cnt == '0) && isDiv;
  assign mif.busy         = (state != IDLE);
  assign mif.stall        = !reset &&
                            (((state == IDLE) && (mif.issue_mult || mif.issue_div)) ||
                             (state == BUSY));

  // Writeback beat in DONE; quiet (all zero) elsewhere.
  always_comb begin
    mif.wb_valid = 1'b0;
    mif.wb_rd    = '0;
    mif.wb_data  = '0;
    if (state == DONE) begin
      if (excReg) begin
        mif.wb_valid = 1'b1;
        mif.wb_rd    = RSTATUS_REG;
        mif.wb_data  = isDiv ? DIV_EXC_CODE : MULT_EXC_CODE;
      end else begin
        mif.wb_valid = (rdReg != '0);
        mif.wb_rd    = rdReg;
        mif.wb_data  = resReg;
      end
    end
  end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencer for the multi-cycle multiplier/divider that feeds the ALU's `multdivAns` path. It accepts a mult/div instruction from the execute stage and latches its operands and destination. It then pulses the unit's start, holds the pipeline stalled until the unit reports ready or a timeout expires, and emits a single writeback beat. On a unit exception or timeout, that beat is redirected to the status register with the standard exception code.

## Interface
Parameters:
- `TIMEOUT`, 40: max BUSY cycles after the start pulse before forced exception; legal range 2..63.
- `CNT_W`, 6: width of the cycle counter.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `issue_mult`  in  1  X-stage holds a valid mul.
- `issue_div`  in  1  X-stage holds a valid div.
- `issue_A`  in  32  operand A.
- `issue_B`  in  32  operand B.
- `issue_rd`  in  5  destination register.
- `md_operandA`  out  32  latched operand A to the unit, stable while busy.
- `md_operandB`  out  32  latched operand B to the unit, stable while busy.
- `md_ctrl_MULT`  out  1  one-cycle mult start pulse.
- `md_ctrl_DIV`  out  1  one-cycle div start pulse.
- `md_result`  in  32  unit result.
- `md_exception`  in  1  unit overflow or divide-by-zero, qualified by `md_resultRDY`.
- `md_resultRDY`  in  1  unit result valid.
- `stall`  out  1  freeze F/D/X latches.
- `busy`  out  1  state is not IDLE.
- `wb_valid`  out  1  one-cycle writeback strobe.
- `wb_rd`  out  5  writeback register.
- `wb_data`  out  32  writeback data.

## Operation
- States are IDLE, BUSY and DONE.
- **IDLE**
  - `issue_mult` or `issue_div` triggers the issue: latch A, B, rd, op and clear the counter, then go to BUSY.
  - If both are high, mult wins and div is ignored.
- **BUSY**
  - `md_ctrl_MULT`/`md_ctrl_DIV` (per latched op) is high only while cnt==0.
  - The counter increments every BUSY cycle.
  - `md_resultRDY` is accepted only when cnt>=1; RDY while cnt==0 is ignored.
  - On accept, register `md_result` and `md_exception` and go to DONE.
  - If cnt==TIMEOUT with no accept, set exception and go to DONE.
- **DONE**
  - Drive the writeback beat, then return to IDLE.
  - `issue_*` is ignored here: it is the same instruction still in X, and it must not re-issue.
- **Writeback mapping**
  - Exception: `wb_rd`=30 and `wb_data`=4 (mult) or 5 (div).
  - Otherwise: `wb_rd`=rd and `wb_data`=result.
  - `wb_valid`=1 except for a no-exception op with rd==0, which gets `wb_valid`=0.
- **Stall and status**
  - `stall` = (IDLE && (`issue_mult`||`issue_div`)) || BUSY. It is combinational on issue and low in DONE.
  - `busy` = state != IDLE.
- Operand registers hold their values through BUSY and DONE; they update only on issue.

## Timing
- **Reset** (any state, including mid-operation) forces:
  - state IDLE, counter 0;
  - all outputs 0, including `md_operand*`, `wb_*` and `stall`;
  - the pending op is discarded with no writeback.
- **Issue at cycle t:**
  - start pulse at t+1;
  - earliest RDY accepted at t+2;
  - DONE/`wb_valid` at t+3;
  - `stall` high t..t+2.
- **RDY accepted at cycle c:** `wb_valid` at c+1, `stall` low at c+1.
- **Timeout:** BUSY spans t+1..t+1+TIMEOUT, DONE at t+2+TIMEOUT (t+42 with default).
- **Back-to-back ops:** a new issue is accepted the cycle after DONE (earliest t+4). The controller never adds bubbles beyond that.
- **Counter width:** `CNT_W` bits; never wraps, because TIMEOUT < 2^CNT_W.
- **Start-pulse edge case:** RDY and an exception arriving on the start cycle are both ignored; the unit must re-assert them later.

## Structure
- **Shared package** `multdiv_pkg`, containing:
  - the state encoding (IDLE, BUSY, DONE);
  - `RSTATUS_REG`=30, `MULT_EXC_CODE`=4, `DIV_EXC_CODE`=5;
  - the default `TIMEOUT`.
- **Sub-module** `md_cycle_counter`: CNT_W-bit counter with synchronous clear, enable and a terminal-count compare against `TIMEOUT`.
- **Top level:** the FSM, operand/rd/op registers, result registers and writeback mux.

## Test plan
- Mult 7×6, rd=5, RDY with no exception at cnt=16 → one start pulse at t+1; `stall` high t..t+17; `wb_valid`@t+18 with rd=5, data=42.
- Div 10/0, rd=3, RDY with exception at cnt=5 → `wb_valid` with rd=30, data=5; no write to rd=3.
- Mult with RDY never asserted → `wb_valid` at t+42 with rd=30, data=4; `stall` drops at t+42.
- Mult to rd=0 with no exception → `wb_valid`=0 in DONE; `stall`/`busy` sequence otherwise normal.
- `issue_mult` held through DONE, then a new `issue_div` at t+4:
  - no second start for the mult;
  - the div start pulse comes at t+5;
  - `issue_mult`+`issue_div` high together → only `md_ctrl_MULT` pulses.
- `reset` asserted at cycle 10 of BUSY, then RDY=1 at cycle 12 → all outputs 0 from the reset edge; RDY ignored in IDLE; no `wb_valid`.
